// File: rtl/cc_object_reader_pkg.sv
// cc_object_reader_pkg: shared widths, data-word field offsets and reader FSM states
package cc_object_reader_pkg;
  localparam int DEF_WORD_SIZE = 8;
  localparam int DEF_OBJ_WIDTH = 128;
  localparam int P_OFF = 0;
  localparam int X_OFF = 1;
  localparam int Y_OFF = 2;
  typedef enum logic [2:0] {IDLE, MT_RD, MT_CHK, DT_CAP, DIV, OUT, NEXT, DONE} state_t;
endpackage

// File: rtl/cc_object_reader_seq_divider.sv
// cc_object_reader_seq_divider: unsigned restoring divider, one quotient bit per cycle, N cycles
module cc_object_reader_seq_divider #(
  parameter int N = 128
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         done,
  output logic [N-1:0] quotient
);
  localparam int CW = $clog2(N + 1);
  logic         busy;
  logic [CW-1:0] cnt;
  logic [N-1:0] rem, den;
  logic [N:0]   trial;
  assign trial = {rem, quotient[N-1]} - {1'b0, den};
  assign done = busy && cnt == 1;
  // quotient shifts in from the dividend's top; borrow bit decides restore vs subtract
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      cnt <= '0;
      rem <= '0;
      den <= '0;
      quotient <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt <= CW'(N);
      rem <= '0;
      den <= divisor;
      quotient <= dividend;
    end else if (busy) begin
      rem <= trial[N] ? {rem[N-2:0], quotient[N-1]} : trial[N-1:0];
      quotient <= {quotient[N-2:0], ~trial[N]};
      cnt <= cnt - 1'b1;
      busy <= cnt != 1;
    end
  end
endmodule

// File: rtl/cc_object_reader.sv
// cc_object_reader: drains root labels from the CC tables and streams area and centroid per object
module cc_object_reader
  import cc_object_reader_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int OBJ_WIDTH = DEF_OBJ_WIDTH,
  parameter int COORD_W   = 32,
  parameter int MIN_AREA  = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [WORD_SIZE-1:0]   num_labels,
  output logic                   busy,
  output logic                   done,
  output logic [WORD_SIZE-1:0]   mt_addr,
  input  logic [WORD_SIZE-1:0]   mt_data,
  output logic [WORD_SIZE-1:0]   dt_addr,
  input  logic [3*OBJ_WIDTH-1:0] dt_data,
  output logic                   obj_valid,
  input  logic                   obj_ready,
  output logic [WORD_SIZE-1:0]   obj_id,
  output logic [OBJ_WIDTH-1:0]   obj_area,
  output logic [COORD_W-1:0]     obj_x,
  output logic [COORD_W-1:0]     obj_y
);
  state_t state, state_n;
  logic [WORD_SIZE:0] l, count;
  logic [WORD_SIZE-1:0] mt_q, dt_q;
  logic [OBJ_WIDTH-1:0] p, qx, qy;
  logic root, keep, div_start, x_done, y_done;
  assign p = dt_data[P_OFF*OBJ_WIDTH +: OBJ_WIDTH];
  assign root = mt_data == l[WORD_SIZE-1:0];
  assign keep = p != '0 && p >= OBJ_WIDTH'(MIN_AREA);
  assign obj_valid = state == OUT;
  assign obj_x = |qx[OBJ_WIDTH-1:COORD_W] ? '1 : qx[COORD_W-1:0];
  assign obj_y = |qy[OBJ_WIDTH-1:COORD_W] ? '1 : qy[COORD_W-1:0];
  cc_object_reader_seq_divider #(.N(OBJ_WIDTH)) u_div_x (
    .clk(clk), .reset(reset), .start(div_start),
    .dividend(dt_data[X_OFF*OBJ_WIDTH +: OBJ_WIDTH]), .divisor(p),
    .done(x_done), .quotient(qx)
  );
  cc_object_reader_seq_divider #(.N(OBJ_WIDTH)) u_div_y (
    .clk(clk), .reset(reset), .start(div_start),
    .dividend(dt_data[Y_OFF*OBJ_WIDTH +: OBJ_WIDTH]), .divisor(p),
    .done(y_done), .quotient(qy)
  );
  // next state, divider launch and table addresses (held outside the read states)
  always_comb begin
    state_n = state;
    div_start = 1'b0;
    mt_addr = state == MT_RD ? l[WORD_SIZE-1:0] : mt_q;
    dt_addr = state == MT_CHK && root ? l[WORD_SIZE-1:0] : dt_q;
    case (state)
      IDLE:    state_n = start ? (num_labels == 1 ? DONE : MT_RD) : IDLE;
      MT_RD:   state_n = MT_CHK;
      MT_CHK:  state_n = root ? DT_CAP : NEXT;
      DT_CAP: begin
        div_start = keep;
        state_n = keep ? DIV : NEXT;
      end
      DIV:     state_n = x_done && y_done ? OUT : DIV;
      OUT:     state_n = obj_ready ? NEXT : OUT;
      NEXT:    state_n = l == count - 1'b1 ? DONE : MT_RD;
      default: state_n = IDLE;
    endcase
  end
  // state, label walk, registered status and object id/area capture
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      l <= 1;
      count <= '0;
      mt_q <= '0;
      dt_q <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      obj_id <= '0;
      obj_area <= '0;
    end else begin
      state <= state_n;
      mt_q <= mt_addr;
      dt_q <= dt_addr;
      busy <= state_n != IDLE;
      done <= state == DONE;
      if (state == IDLE && start) begin
        l <= 1;
        count <= num_labels == '0 ? {1'b1, {WORD_SIZE{1'b0}}} : {1'b0, num_labels};
      end
      if (state == NEXT && state_n == MT_RD) l <= l + 1'b1;
      if (state == DT_CAP) begin
        obj_id <= l[WORD_SIZE-1:0];
        obj_area <= p;
      end
    end
  end
endmodule

// File: tb/tb_cc_object_reader.sv
// tb_cc_object_reader: directed scenarios for the CC object reader, with a MIN_AREA=5 twin
module tb_cc_object_reader;
  logic clk = 1'b0;
  logic reset = 1'b1, start = 1'b0, obj_ready = 1'b1;
  logic [7:0] num_labels = 8'd0;
  logic busy, done, obj_valid, busy2, done2, obj_valid2;
  logic [7:0] mt_addr, mt_data, dt_addr, obj_id, mt_addr2, mt_data2, dt_addr2, obj_id2;
  logic [383:0] dt_data, dt_data2;
  logic [127:0] obj_area, obj_area2;
  logic [31:0] obj_x, obj_y, obj_x2, obj_y2;
  logic [7:0] mt_mem [256];
  logic [383:0] dt_mem [256];
  logic [7:0] b_id [$];
  logic [7:0] b2_id [$];
  logic [127:0] b_area [$];
  logic [31:0] b_x [$];
  logic [31:0] b_y [$];
  int b_cyc [$];
  int cyc = 0, start_cyc = 0, done_cyc = -1, done2_cyc = -1;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  cc_object_reader dut (
    .clk(clk), .reset(reset), .start(start), .num_labels(num_labels),
    .busy(busy), .done(done), .mt_addr(mt_addr), .mt_data(mt_data),
    .dt_addr(dt_addr), .dt_data(dt_data), .obj_valid(obj_valid), .obj_ready(obj_ready),
    .obj_id(obj_id), .obj_area(obj_area), .obj_x(obj_x), .obj_y(obj_y)
  );

  cc_object_reader #(.MIN_AREA(5)) dut2 (
    .clk(clk), .reset(reset), .start(start), .num_labels(num_labels),
    .busy(busy2), .done(done2), .mt_addr(mt_addr2), .mt_data(mt_data2),
    .dt_addr(dt_addr2), .dt_data(dt_data2), .obj_valid(obj_valid2), .obj_ready(obj_ready),
    .obj_id(obj_id2), .obj_area(obj_area2), .obj_x(obj_x2), .obj_y(obj_y2)
  );

  // synchronous-read table models and cycle counter
  always @(posedge clk) begin
    cyc <= cyc + 1;
    mt_data <= mt_mem[mt_addr];
    dt_data <= dt_mem[dt_addr];
    mt_data2 <= mt_mem[mt_addr2];
    dt_data2 <= dt_mem[dt_addr2];
  end

  // beat and done logger
  always @(negedge clk) begin
    if (obj_valid && obj_ready) begin
      b_id.push_back(obj_id);
      b_area.push_back(obj_area);
      b_x.push_back(obj_x);
      b_y.push_back(obj_y);
      b_cyc.push_back(cyc);
    end
    if (obj_valid2 && obj_ready) b2_id.push_back(obj_id2);
    if (done) done_cyc = cyc;
    if (done2) done2_cyc = cyc;
  end

  function automatic logic [383:0] dtw(input logic [127:0] y, input logic [127:0] x, input logic [127:0] p);
    return {y, x, p};
  endfunction

  task automatic init_tables();
    for (int i = 0; i < 256; i++) begin
      mt_mem[i] = 8'(i);
      dt_mem[i] = '0;
    end
  endtask

  task automatic clear_log();
    b_id.delete();
    b2_id.delete();
    b_area.delete();
    b_x.delete();
    b_y.delete();
    b_cyc.delete();
    done_cyc = -1;
    done2_cyc = -1;
  endtask

  task automatic pulse_start(input logic [7:0] n);
    @(negedge clk);
    num_labels = n;
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int k = 0;
    while ((done_cyc < 0 || done2_cyc < 0) && k < bound) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    tests++;
    if (done_cyc < 0 || done2_cyc < 0) begin
      fails++;
      $display("FAIL wait_done: done=%0d done2=%0d not both seen within %0d cycles", done_cyc, done2_cyc, bound);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({busy, done, obj_valid, mt_addr, dt_addr, obj_id} !== 27'd0) begin
      fails++;
      $display("FAIL reset_ctrl: got %h want 0", {busy, done, obj_valid, mt_addr, dt_addr, obj_id});
    end
    tests++;
    if ({obj_area, obj_x, obj_y} !== 192'd0) begin
      fails++;
      $display("FAIL reset_obj: got %h want 0", {obj_area, obj_x, obj_y});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_count1();
    init_tables();
    clear_log();
    pulse_start(8'd1);
    tests++;
    if ({busy, done} !== 2'b10) begin
      fails++;
      $display("FAIL count1_c1: busy,done got %b want 10", {busy, done});
    end
    @(negedge clk);
    tests++;
    if ({busy, done} !== 2'b01) begin
      fails++;
      $display("FAIL count1_c2: busy,done got %b want 01", {busy, done});
    end
    @(negedge clk);
    tests++;
    if ({busy, done, obj_valid} !== 3'b000 || b_id.size() != 0) begin
      fails++;
      $display("FAIL count1_after: busy,done,valid got %b beats %0d want 000 beats 0", {busy, done, obj_valid}, b_id.size());
    end
  endtask

  task automatic test_two_roots();
    init_tables();
    dt_mem[1] = dtw(40, 20, 4);
    dt_mem[2] = dtw(90, 30, 10);
    clear_log();
    pulse_start(8'd3);
    wait_done(1000);
    tests++;
    if (b_id.size() != 2) begin
      fails++;
      $display("FAIL two_roots_count: got %0d beats want 2", b_id.size());
    end else begin
      tests++;
      if ({b_id[0], b_x[0], b_y[0], b_area[0]} !== {8'd1, 32'd5, 32'd10, 128'd4}) begin
        fails++;
        $display("FAIL two_roots_beat0: got %h want %h", {b_id[0], b_x[0], b_y[0], b_area[0]}, {8'd1, 32'd5, 32'd10, 128'd4});
      end
      tests++;
      if ({b_id[1], b_x[1], b_y[1], b_area[1]} !== {8'd2, 32'd3, 32'd9, 128'd10}) begin
        fails++;
        $display("FAIL two_roots_beat1: got %h want %h", {b_id[1], b_x[1], b_y[1], b_area[1]}, {8'd2, 32'd3, 32'd9, 128'd10});
      end
      tests++;
      if (b_cyc[0] - start_cyc != 132 || b_cyc[1] - b_cyc[0] != 133) begin
        fails++;
        $display("FAIL two_roots_latency: got %0d/%0d want 132/133", b_cyc[0] - start_cyc, b_cyc[1] - b_cyc[0]);
      end
    end
    tests++;
    if (done_cyc - start_cyc != 268 || busy !== 1'b0) begin
      fails++;
      $display("FAIL two_roots_done: latency %0d busy %b want 268 busy 0", done_cyc - start_cyc, busy);
    end
  endtask

  task automatic test_merged();
    init_tables();
    mt_mem[3] = 8'd1;
    dt_mem[1] = dtw(40, 20, 4);
    dt_mem[2] = dtw(90, 30, 10);
    dt_mem[3] = dtw(7, 7, 7);
    clear_log();
    pulse_start(8'd4);
    wait_done(1000);
    tests++;
    if (b_id.size() != 2) begin
      fails++;
      $display("FAIL merged_count: got %0d beats want 2", b_id.size());
    end else begin
      tests++;
      if ({b_id[0], b_id[1]} !== 16'h0102) begin
        fails++;
        $display("FAIL merged_ids: got %h want 0102", {b_id[0], b_id[1]});
      end
    end
    tests++;
    if (done_cyc - start_cyc != 271) begin
      fails++;
      $display("FAIL merged_done: latency got %0d want 271", done_cyc - start_cyc);
    end
  endtask

  task automatic test_min_area();
    init_tables();
    dt_mem[1] = dtw(40, 20, 4);
    dt_mem[2] = dtw(90, 30, 10);
    dt_mem[3] = dtw(50, 50, 0);
    clear_log();
    pulse_start(8'd4);
    wait_done(1000);
    tests++;
    if (b2_id.size() != 1) begin
      fails++;
      $display("FAIL min_area_count: got %0d beats want 1", b2_id.size());
    end else begin
      tests++;
      if (b2_id[0] !== 8'd2) begin
        fails++;
        $display("FAIL min_area_id: got %0d want 2", b2_id[0]);
      end
    end
    tests++;
    if (done2_cyc - start_cyc != 143) begin
      fails++;
      $display("FAIL min_area_done: latency got %0d want 143", done2_cyc - start_cyc);
    end
    tests++;
    if (b_id.size() != 2 || done_cyc - start_cyc != 272) begin
      fails++;
      $display("FAIL zero_area_skip: beats %0d latency %0d want 2 and 272", b_id.size(), done_cyc - start_cyc);
    end
  endtask

  task automatic test_stall();
    int k = 0;
    init_tables();
    dt_mem[1] = dtw(40, 20, 4);
    clear_log();
    obj_ready = 1'b0;
    pulse_start(8'd2);
    while (!obj_valid && k < 400) begin
      @(negedge clk);
      k++;
    end
    for (int i = 0; i < 20; i++) begin
      tests++;
      if (obj_valid !== 1'b1 || {obj_id, obj_x, obj_y, obj_area} !== {8'd1, 32'd5, 32'd10, 128'd4}) begin
        fails++;
        $display("FAIL stall_hold[%0d]: valid %b fields %h want 1 %h", i, obj_valid, {obj_id, obj_x, obj_y, obj_area}, {8'd1, 32'd5, 32'd10, 128'd4});
      end
      @(negedge clk);
      start = i == 5;
    end
    start = 1'b0;
    obj_ready = 1'b1;
    wait_done(100);
    repeat (5) @(negedge clk);
    tests++;
    if (b_id.size() != 1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL stall_release: beats %0d busy %b want 1 beat busy 0", b_id.size(), busy);
    end
  endtask

  task automatic test_saturate();
    init_tables();
    dt_mem[1] = dtw(5, 128'd1 << 40, 1);
    clear_log();
    pulse_start(8'd2);
    wait_done(500);
    tests++;
    if (b_id.size() != 1) begin
      fails++;
      $display("FAIL saturate_count: got %0d beats want 1", b_id.size());
    end else begin
      tests++;
      if ({b_x[0], b_y[0], b_area[0]} !== {32'hffff_ffff, 32'd5, 128'd1}) begin
        fails++;
        $display("FAIL saturate_beat: got %h want %h", {b_x[0], b_y[0], b_area[0]}, {32'hffff_ffff, 32'd5, 128'd1});
      end
    end
  endtask

  task automatic test_reset_mid();
    init_tables();
    dt_mem[1] = dtw(40, 20, 4);
    dt_mem[2] = dtw(90, 30, 10);
    clear_log();
    pulse_start(8'd3);
    repeat (60) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if ({busy, obj_valid, done, mt_addr, dt_addr} !== 19'd0) begin
      fails++;
      $display("FAIL reset_mid: busy,valid,done,mt,dt got %h want 0", {busy, obj_valid, done, mt_addr, dt_addr});
    end
    reset = 1'b0;
    @(negedge clk);
    clear_log();
    pulse_start(8'd3);
    wait_done(1000);
    tests++;
    if (b_id.size() != 2) begin
      fails++;
      $display("FAIL rerun_count: got %0d beats want 2", b_id.size());
    end else begin
      tests++;
      if ({b_id[0], b_x[0], b_y[0], b_id[1], b_x[1], b_y[1]} !== {8'd1, 32'd5, 32'd10, 8'd2, 32'd3, 32'd9} || b_cyc[0] - start_cyc != 132) begin
        fails++;
        $display("FAIL rerun_beats: got %h lat %0d want %h lat 132", {b_id[0], b_x[0], b_y[0], b_id[1], b_x[1], b_y[1]}, b_cyc[0] - start_cyc, {8'd1, 32'd5, 32'd10, 8'd2, 32'd3, 32'd9});
      end
    end
  endtask

  task automatic test_count0();
    init_tables();
    for (int i = 1; i < 256; i++) mt_mem[i] = 8'd0;
    mt_mem[7] = 8'd7;
    mt_mem[255] = 8'd255;
    dt_mem[255] = dtw(600, 300, 3);
    clear_log();
    pulse_start(8'd0);
    wait_done(2000);
    tests++;
    if (b_id.size() != 1) begin
      fails++;
      $display("FAIL count0_count: got %0d beats want 1", b_id.size());
    end else begin
      tests++;
      if ({b_id[0], b_x[0], b_y[0], b_area[0]} !== {8'd255, 32'd100, 32'd200, 128'd3}) begin
        fails++;
        $display("FAIL count0_beat: got %h want %h", {b_id[0], b_x[0], b_y[0], b_area[0]}, {8'd255, 32'd100, 32'd200, 128'd3});
      end
    end
    tests++;
    if (done_cyc - start_cyc != 898) begin
      fails++;
      $display("FAIL count0_done: latency got %0d want 898", done_cyc - start_cyc);
    end
  endtask

  initial begin
    init_tables();
    test_reset();
    test_count1();
    test_two_roots();
    test_merged();
    test_min_area();
    test_stall();
    test_saturate();
    test_reset_mid();
    test_count0();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
